// File: rtl/spwm_deadtime_if.sv
// spwm_deadtime_if: control inputs and gate-drive outputs of the dead-time stage
interface spwm_deadtime_if #(parameter int DT_W = 8);
  logic            en;
  logic            pwm_in;
  logic [DT_W-1:0] dt_cycles;
  logic            fault_in;
  logic            fault_clr;
  logic            hs_out;
  logic            ls_out;
  logic            fault_flag;
  logic            dead_active;
  logic [7:0]      restart_cnt;
  modport master (output en, pwm_in, dt_cycles, fault_in, fault_clr,
                  input  hs_out, ls_out, fault_flag, dead_active, restart_cnt);
  modport slave  (input  en, pwm_in, dt_cycles, fault_in, fault_clr,
                  output hs_out, ls_out, fault_flag, dead_active, restart_cnt);
endinterface

// File: rtl/spwm_deadtime.sv
// spwm_deadtime: complementary half-bridge drive with dead time, pulse swallowing and latching fault
module spwm_deadtime #(
  parameter int DT_W       = 8,
  parameter int DT_DEFAULT = 50
) (
  input logic             clk,
  input logic             rst,
  spwm_deadtime_if.slave  bus
);
  typedef enum logic [2:0] {OFF, DEAD, HI, LO, FAULT} state_t;
  state_t          r_state, w_nxt;
  logic            r_tgt, w_tgt;
  logic [DT_W-1:0] r_cnt, w_cnt, w_eff_dt;
  logic [7:0]      r_restart;
  logic            w_restart;
  logic            r_hs, r_ls, r_dead, r_fault;
  assign w_eff_dt = (bus.dt_cycles == '0) ? DT_W'(DT_DEFAULT) : bus.dt_cycles;
  // next state: fault beats disable beats normal transitions; dead time ends when the counter reaches 1
  always_comb begin
    w_nxt     = r_state;
    w_tgt     = r_tgt;
    w_cnt     = r_cnt;
    w_restart = 1'b0;
    if (bus.fault_in) w_nxt = FAULT;
    else if (r_state == FAULT) w_nxt = bus.fault_clr ? OFF : FAULT;
    else if (!bus.en) w_nxt = OFF;
    else begin
      case (r_state)
        OFF: begin
          w_nxt = DEAD;
          w_tgt = bus.pwm_in;
          w_cnt = w_eff_dt;
        end
        DEAD: begin
          if (bus.pwm_in != r_tgt) begin
            w_tgt     = bus.pwm_in;
            w_cnt     = w_eff_dt;
            w_restart = 1'b1;
          end else if (r_cnt == DT_W'(1)) w_nxt = r_tgt ? HI : LO;
          else w_cnt = r_cnt - DT_W'(1);
        end
        HI, LO: begin
          if (bus.pwm_in != (r_state == HI)) begin
            w_nxt = DEAD;
            w_tgt = bus.pwm_in;
            w_cnt = w_eff_dt;
          end
        end
        default: w_nxt = OFF;
      endcase
    end
  end
  // state, counter and outputs registered from the next state so outputs change on the deciding edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= OFF;
      r_tgt     <= 1'b0;
      r_cnt     <= '0;
      r_restart <= '0;
      r_hs      <= 1'b0;
      r_ls      <= 1'b0;
      r_dead    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_tgt   <= w_tgt;
      r_cnt   <= w_cnt;
      r_hs    <= w_nxt == HI;
      r_ls    <= w_nxt == LO;
      r_dead  <= w_nxt == DEAD;
      r_fault <= w_nxt == FAULT;
      if (w_restart && r_restart != 8'hFF) r_restart <= r_restart + 8'd1;
    end
  end
  assign bus.hs_out      = r_hs;
  assign bus.ls_out      = r_ls;
  assign bus.dead_active = r_dead;
  assign bus.fault_flag  = r_fault;
  assign bus.restart_cnt = r_restart;
endmodule

// File: doc/spwm_deadtime.md
Name: spwm_deadtime

Overview:
- Downstream stage of the SPWM generator. Consumes its single-ended pwm_out and produces a complementary high-side/low-side gate-drive pair for a half-bridge leg.
- Inserts a programmable dead time on every transition and suppresses PWM pulses shorter than the dead time.
- Provides a latching fault shutdown.
- Runs in the 100 MHz PLL clock domain, the same domain as the SPWM generator, so pwm_in needs no synchronizer.

Parameters:
- DT_W, 8, width of the dead-time count input.
- DT_DEFAULT, 50, dead time in clk cycles used while dt_cycles==0 (50 cycles = 500 ns at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz from PLL.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  bridge enable; low forces both outputs off.
- pwm_in  input  1  SPWM stream; 1 requests high side, 0 requests low side.
- dt_cycles  input  DT_W  dead time in clk cycles; 0 selects DT_DEFAULT.
- fault_in  input  1  synchronous fault request, level-sensitive.
- fault_clr  input  1  single-cycle fault acknowledge.
- hs_out  output  1  high-side gate drive, registered.
- ls_out  output  1  low-side gate drive, registered.
- fault_flag  output  1  latched fault indicator.
- dead_active  output  1  high while in a dead-time state.
- restart_cnt  output  8  saturating count of dead-time restarts (swallowed pulses).

Behaviour:
- Reset (rst=0, asynchronous): state=OFF, hs_out=0, ls_out=0, fault_flag=0, dead_active=0, restart_cnt=0, counter=0.
- All outputs are registered. hs_out and ls_out are never both 1 on any cycle; this is an invariant.
- States: OFF, DEAD, HI, LO, FAULT. DEAD holds a 1-bit target and a down-counter.
- Priority per cycle: fault_in > en=0 > normal transitions.
- OFF: both outputs 0.
  - en=1 -> DEAD with target=pwm_in and counter=eff_dt.
  - eff_dt = dt_cycles, or DT_DEFAULT if dt_cycles==0. eff_dt is sampled only when loading the counter.
- DEAD: both outputs 0, dead_active=1. Each cycle:
  - If pwm_in != target: target<=pwm_in, counter<=eff_dt (restart), restart_cnt increments, saturating at 255.
  - Else if counter==1: go to HI if target=1, else LO.
  - Else: counter decrements.
- HI: hs_out=1. pwm_in=0 -> DEAD with target=0, counter=eff_dt; hs_out drops on the same edge.
- LO: ls_out=1. pwm_in=1 -> DEAD with target=1, counter=eff_dt.
- Timing:
  - A pwm_in change sampled at edge N deasserts the active output at edge N+1.
  - The opposite output asserts at edge N+1+eff_dt.
  - The gap with both outputs low is exactly eff_dt cycles.
- en=0 in any non-FAULT state -> OFF at the next edge, both outputs 0 immediately. No dead time is needed for turn-off.
- fault_in=1 in any state -> FAULT at the next edge: both outputs 0, fault_flag=1.
- FAULT: outputs 0. Exit to OFF only when fault_clr=1 and fault_in=0 on the same edge. fault_clr with fault_in=1 is ignored.
- From OFF, en=1 re-enters through DEAD, so the first output after reset, enable or fault recovery is always delayed by a full dead time.
- dt_cycles changing mid-dead-time has no effect until the next counter load.
- Pulses on pwm_in of width ≤ eff_dt never reach the outputs.

Test Plan:
1. Reset release, en=1, pwm_in=1, dt_cycles=10 -> both outputs 0 for 10 cycles, dead_active=1; hs_out=1 on cycle 11 after en is sampled.
2. Square wave on pwm_in, period 400 cycles, dt_cycles=0 -> each transition shows exactly 50 cycles with both outputs low; hs_out never overlaps ls_out (checked every cycle); restart_cnt=0.
3. While in HI with dt_cycles=20, a 5-cycle low glitch on pwm_in -> hs_out drops, the DEAD state restarts once, and hs_out returns 20 cycles after pwm_in returns high; ls_out stays 0; restart_cnt=1.
4. fault_in pulsed 1 cycle during LO -> ls_out=0 and fault_flag=1 next edge, held. fault_clr with fault_in=1 -> still FAULT. fault_clr with fault_in=0 -> OFF, then DEAD for eff_dt cycles, then output resumes.
5. en dropped during DEAD and during HI -> both outputs 0 next edge, state OFF. Asynchronous rst asserted mid-DEAD -> outputs 0 immediately without waiting for a clock edge.
6. 300 sub-dead-time glitches -> restart_cnt saturates at 255 and does not wrap.
